// File: rtl/vm_arbiter.sv
// rtl/vm_arbiter.sv - round-robin arbiter sharing the video-memory read port between masters A and B.
// Define VM_ARB_TIMEOUT_EN to add a downstream wait timeout with a sticky err_timeout flag.
module vm_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_bus_enable,
  input  logic              a_rw,
  output logic [DATA_W-1:0] a_read_data,
  output logic              a_acknowledge,
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_bus_enable,
  input  logic              b_rw,
  output logic [DATA_W-1:0] b_read_data,
  output logic              b_acknowledge,
  output logic [ADDR_W-1:0] vm_address,
  output logic              vm_bus_enable,
  output logic              vm_rw,
  input  logic [DATA_W-1:0] vm_read_data,
  input  logic              vm_acknowledge,
  output logic              busy,
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic [ADDR_W-1:0] vm_address_q, vm_address_d;
  logic              vm_rw_q, vm_rw_d;
  logic              vm_bus_enable_q, vm_bus_enable_d;
  logic [DATA_W-1:0] a_read_data_q, a_read_data_d;
  logic [DATA_W-1:0] b_read_data_q, b_read_data_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              any_req;
  logic              pick_b;
  logic              tmo_hit;
  logic              finish;

  assign any_req = a_bus_enable | b_bus_enable;
  // B wins only when A is absent or A was served last.
  assign pick_b  = b_bus_enable & (~a_bus_enable | ~last_b_q);

`ifdef VM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign tmo_hit = (state_q == ST_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign finish = (state_q == ST_WAIT) && (vm_acknowledge || tmo_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_WAIT;
      ST_WAIT: if (finish)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // last_b_q doubles as the owner of the transaction in flight.
  always_comb begin
    last_b_d        = last_b_q;
    vm_address_d    = vm_address_q;
    vm_rw_d         = vm_rw_q;
    vm_bus_enable_d = vm_bus_enable_q;
    a_read_data_d   = a_read_data_q;
    b_read_data_d   = b_read_data_q;
    a_ack_d         = 1'b0;
    b_ack_d         = 1'b0;
    err_d           = err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          last_b_d        = pick_b;
          vm_address_d    = pick_b ? b_address : a_address;
          vm_rw_d         = pick_b ? b_rw : a_rw;
          vm_bus_enable_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (finish) begin
          vm_bus_enable_d = 1'b0;
          // A real ack takes priority over a timeout landing on the same edge.
          if (last_b_q) begin
            b_read_data_d = vm_acknowledge ? vm_read_data : '0;
            b_ack_d       = 1'b1;
          end else begin
            a_read_data_d = vm_acknowledge ? vm_read_data : '0;
            a_ack_d       = 1'b1;
          end
          if (!vm_acknowledge) begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q        <= 1'b1;
      vm_address_q    <= '0;
      vm_rw_q         <= 1'b1;
      vm_bus_enable_q <= 1'b0;
      a_read_data_q   <= '0;
      b_read_data_q   <= '0;
      a_ack_q         <= 1'b0;
      b_ack_q         <= 1'b0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      last_b_q        <= last_b_d;
      vm_address_q    <= vm_address_d;
      vm_rw_q         <= vm_rw_d;
      vm_bus_enable_q <= vm_bus_enable_d;
      a_read_data_q   <= a_read_data_d;
      b_read_data_q   <= b_read_data_d;
      a_ack_q         <= a_ack_d;
      b_ack_q         <= b_ack_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
    end
  end

  assign vm_address    = vm_address_q;
  assign vm_rw         = vm_rw_q;
  assign vm_bus_enable = vm_bus_enable_q;
  assign a_read_data   = a_read_data_q;
  assign b_read_data   = b_read_data_q;
  assign a_acknowledge = a_ack_q;
  assign b_acknowledge = b_ack_q;
  assign busy          = busy_q;
  assign err_timeout   = err_q;

endmodule
